// File: rtl/led_seq_ctrl.sv
// Multi-channel LED pattern sequencer.
// Each channel runs OFF, SOLID, BLINK or BURST patterns timed by one shared tick prescaler.
// Channels are loaded through a valid/ready command port; ready is high from the first cycle
// after reset and stays high.
// Optional build macro LED_ACTIVE_LOW_EN: when defined, o_led is the inverse of the lit state.
module led_seq_ctrl #(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned TICK_DIV = 25,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_led,
  input  logic [1:0]       i_cmd_mode,
  input  logic [CNT_W-1:0] i_cmd_on,
  input  logic [CNT_W-1:0] i_cmd_off,
  input  logic [CNT_W-1:0] i_cmd_rep,
  output logic [N_LED-1:0] o_led,
  output logic [N_LED-1:0] o_done,
  output logic             o_tick
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeSolid = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPhOn  = 2'd1,
    StPhOff = 2'd2
  } state_e;

  // Shared timebase
  logic [PreW-1:0] pre_q, pre_d;
  logic            ready_q, ready_d;
  logic            tick;

  // Per-channel state; on/off hold the phase length minus one, ready for reload
  mode_e            mode_q [N_LED];
  mode_e            mode_d [N_LED];
  state_e           st_q   [N_LED];
  state_e           st_d   [N_LED];
  logic [CNT_W-1:0] cnt_q  [N_LED];
  logic [CNT_W-1:0] cnt_d  [N_LED];
  logic [CNT_W-1:0] rep_q  [N_LED];
  logic [CNT_W-1:0] rep_d  [N_LED];
  logic [CNT_W-1:0] on_q   [N_LED];
  logic [CNT_W-1:0] on_d   [N_LED];
  logic [CNT_W-1:0] off_q  [N_LED];
  logic [CNT_W-1:0] off_d  [N_LED];
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] done_q, done_d;

  // Decoded command fields; zero lengths are promoted to one
  logic             cmd_fire;
  logic [CNT_W-1:0] cmd_on_m1;
  logic [CNT_W-1:0] cmd_off_m1;
  logic [CNT_W-1:0] cmd_rep_c;

  // Prescaler only starts once ready is up, so the first tick lands TICK_DIV cycles after reset
  always_comb begin
    ready_d = 1'b1;
    pre_d   = pre_q;
    tick    = (pre_q == PreMax);
    if (ready_q) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
    end
  end

  // Command handshake and field normalisation
  always_comb begin
    cmd_fire   = i_cmd_valid & ready_q;
    cmd_on_m1  = (i_cmd_on == '0) ? '0 : i_cmd_on - CNT_W'(1);
    cmd_off_m1 = (i_cmd_off == '0) ? '0 : i_cmd_off - CNT_W'(1);
    cmd_rep_c  = (i_cmd_rep == '0) ? CNT_W'(1) : i_cmd_rep;
  end

  // Per-channel next state; a command on a channel takes priority over a coincident tick
  always_comb begin
    done_d = '0;
    led_d  = led_q;
    for (int ch = 0; ch < N_LED; ch++) begin
      mode_d[ch] = mode_q[ch];
      st_d[ch]   = st_q[ch];
      cnt_d[ch]  = cnt_q[ch];
      rep_d[ch]  = rep_q[ch];
      on_d[ch]   = on_q[ch];
      off_d[ch]  = off_q[ch];

      if (cmd_fire && (i_cmd_led == 4'(ch))) begin
        mode_d[ch] = mode_e'(i_cmd_mode);
        on_d[ch]   = cmd_on_m1;
        off_d[ch]  = cmd_off_m1;
        unique case (mode_e'(i_cmd_mode))
          ModeOff: begin
            st_d[ch]  = StIdle;
            cnt_d[ch] = '0;
            rep_d[ch] = '0;
            led_d[ch] = 1'b0;
          end
          ModeSolid: begin
            st_d[ch]  = StIdle;
            cnt_d[ch] = '0;
            rep_d[ch] = '0;
            led_d[ch] = 1'b1;
          end
          ModeBlink, ModeBurst: begin
            st_d[ch]  = StPhOn;
            cnt_d[ch] = cmd_on_m1;
            rep_d[ch] = cmd_rep_c;
            led_d[ch] = 1'b1;
          end
        endcase
      end else if (tick) begin
        unique case (st_q[ch])
          StPhOn: begin
            if (cnt_q[ch] == '0) begin
              st_d[ch]  = StPhOff;
              cnt_d[ch] = off_q[ch];
              led_d[ch] = 1'b0;
            end else begin
              cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
            end
          end
          StPhOff: begin
            if (cnt_q[ch] != '0) begin
              cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
            end else if (mode_q[ch] == ModeBlink) begin
              st_d[ch]  = StPhOn;
              cnt_d[ch] = on_q[ch];
              led_d[ch] = 1'b1;
            end else if (rep_q[ch] > CNT_W'(1)) begin
              rep_d[ch] = rep_q[ch] - CNT_W'(1);
              st_d[ch]  = StPhOn;
              cnt_d[ch] = on_q[ch];
              led_d[ch] = 1'b1;
            end else begin
              // Last burst pulse finished: fall back to OFF and flag completion
              mode_d[ch] = ModeOff;
              st_d[ch]   = StIdle;
              rep_d[ch]  = '0;
              led_d[ch]  = 1'b0;
              done_d[ch] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      done_q  <= '0;
      for (int ch = 0; ch < N_LED; ch++) begin
        mode_q[ch] <= ModeOff;
        st_q[ch]   <= StIdle;
        cnt_q[ch]  <= '0;
        rep_q[ch]  <= '0;
        on_q[ch]   <= '0;
        off_q[ch]  <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      ready_q <= ready_d;
      led_q   <= led_d;
      done_q  <= done_d;
      for (int ch = 0; ch < N_LED; ch++) begin
        mode_q[ch] <= mode_d[ch];
        st_q[ch]   <= st_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
        rep_q[ch]  <= rep_d[ch];
        on_q[ch]   <= on_d[ch];
        off_q[ch]  <= off_d[ch];
      end
    end
  end

  // Output mapping
  always_comb begin
    o_cmd_ready = ready_q;
    o_tick      = tick;
    o_done      = done_q;
`ifdef LED_ACTIVE_LOW_EN
    o_led       = ~led_q;
`else
    o_led       = led_q;
`endif
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl (N_LED=4, TICK_DIV=4, CNT_W=8).
// Expected LED values follow LED_ACTIVE_LOW_EN when the bench is built with it.
module tb_led_seq_ctrl;

  localparam int unsigned NLed    = 4;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned CntW    = 8;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic [3:0]      i_cmd_led;
  logic [1:0]      i_cmd_mode;
  logic [CntW-1:0] i_cmd_on;
  logic [CntW-1:0] i_cmd_off;
  logic [CntW-1:0] i_cmd_rep;
  logic [NLed-1:0] o_led;
  logic [NLed-1:0] o_done;
  logic            o_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  led_seq_ctrl #(
    .N_LED    (NLed),
    .TICK_DIV (TickDiv),
    .CNT_W    (CntW)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_led   (i_cmd_led),
    .i_cmd_mode  (i_cmd_mode),
    .i_cmd_on    (i_cmd_on),
    .i_cmd_off   (i_cmd_off),
    .i_cmd_rep   (i_cmd_rep),
    .o_led       (o_led),
    .o_done      (o_done),
    .o_tick      (o_tick)
  );

  always #5 i_clk = ~i_clk;

  // Cycle index since reset release: cycle k is the interval after the k-th released edge
  always @(posedge i_clk) begin
    if (i_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [3:0] led_exp(input logic [3:0] lit);
`ifdef LED_ACTIVE_LOW_EN
    return ~lit;
`else
    return lit;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle of the new mode
  task automatic send_cmd(input logic [3:0] led, input logic [1:0] mode,
                          input logic [7:0] on, input logic [7:0] off, input logic [7:0] rep);
    i_cmd_valid = 1'b1;
    i_cmd_led   = led;
    i_cmd_mode  = mode;
    i_cmd_on    = on;
    i_cmd_off   = off;
    i_cmd_rep   = rep;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 8 && (cyc % 4) != p; i++) @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    logic [3:0] d;
    int s0;
    int s1;
    int k;

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_led   = '0;
    i_cmd_mode  = '0;
    i_cmd_on    = '0;
    i_cmd_off   = '0;
    i_cmd_rep   = '0;

    // Reset and timebase
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_led", o_led, led_exp(4'b0000));
    chk("rst_ready", o_cmd_ready, 1'b0);
    chk("rst_tick", o_tick, 1'b0);
    chk("rst_done", o_done, 4'b0000);
    i_rst = 1'b0;
    @(negedge i_clk);
    for (int c = 1; c <= 12; c++) begin
      chk("tick", o_tick, (c % 4) == 0);
      chk("ready", o_cmd_ready, 1'b1);
      if (c < 12) @(negedge i_clk);
    end

    // SOLID then OFF on channel 2
    send_cmd(4'd2, 2'd1, 8'd0, 8'd0, 8'd0);
    chk("solid_on", o_led, led_exp(4'b0100));
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      chk("solid_hold", o_led, led_exp(4'b0100));
    end
    send_cmd(4'd2, 2'd0, 8'd0, 8'd0, 8'd0);
    chk("solid_off", o_led, led_exp(4'b0000));

    // BLINK on=2 off=3: first on phase 7 cycles, then 12 low / 8 high
    wait_phase(1);
    send_cmd(4'd0, 2'd2, 8'd2, 8'd3, 8'd0);
    for (int r = 0; r < 47; r++) begin
      if (r < 7) e = 4'b0001;
      else e = (((r - 7) % 20) < 12) ? 4'b0000 : 4'b0001;
      chk("blink_led", o_led, led_exp(e));
      chk("blink_done", o_done, 4'b0000);
      @(negedge i_clk);
    end
    send_cmd(4'd0, 2'd0, 8'd0, 8'd0, 8'd0);
    chk("blink_stop", o_led, led_exp(4'b0000));

    // BURST on=1 off=1 rep=3 on channel 1
    wait_phase(1);
    send_cmd(4'd1, 2'd3, 8'd1, 8'd1, 8'd3);
    for (int r = 0; r < 31; r++) begin
      e = ((r <= 2) || (r >= 7 && r <= 10) || (r >= 15 && r <= 18)) ? 4'b0010 : 4'b0000;
      d = (r == 23) ? 4'b0010 : 4'b0000;
      chk("burst_led", o_led, led_exp(e));
      chk("burst_done", o_done, d);
      @(negedge i_clk);
    end

    // Override a running burst with SOLID: no completion pulse
    wait_phase(1);
    send_cmd(4'd1, 2'd3, 8'd1, 8'd1, 8'd3);
    repeat (8) @(negedge i_clk);
    chk("ovr_mid", o_led, led_exp(4'b0010));
    send_cmd(4'd1, 2'd1, 8'd0, 8'd0, 8'd0);
    for (int r = 0; r < 30; r++) begin
      chk("ovr_led", o_led, led_exp(4'b0010));
      chk("ovr_done", o_done, 4'b0000);
      @(negedge i_clk);
    end
    send_cmd(4'd1, 2'd0, 8'd0, 8'd0, 8'd0);

    // Zero-length fields behave as one tick
    wait_phase(1);
    send_cmd(4'd3, 2'd2, 8'd0, 8'd0, 8'd0);
    for (int r = 0; r < 15; r++) begin
      if (r < 3) e = 4'b1000;
      else e = (((r - 3) / 4) % 2 == 1) ? 4'b1000 : 4'b0000;
      chk("zero_led", o_led, led_exp(e));
      @(negedge i_clk);
    end
    send_cmd(4'd3, 2'd0, 8'd0, 8'd0, 8'd0);

    // Out-of-range channel indices are ignored
    send_cmd(4'd5, 2'd1, 8'd0, 8'd0, 8'd0);
    chk("oor5", o_led, led_exp(4'b0000));
    send_cmd(4'd15, 2'd2, 8'd1, 8'd1, 8'd0);
    for (int r = 0; r < 8; r++) begin
      chk("oor15", o_led, led_exp(4'b0000));
      @(negedge i_clk);
    end

    // Command coincident with a tick: channel 1 ignores it, channel 0 still advances
    wait_phase(1);
    send_cmd(4'd0, 2'd2, 8'd1, 8'd1, 8'd0);
    s0 = cyc;
    wait_phase(0);
    chk("coin_tick", o_tick, 1'b1);
    send_cmd(4'd1, 2'd2, 8'd1, 8'd1, 8'd0);
    s1 = cyc;
    for (int r = 0; r < 16; r++) begin
      k = cyc;
      e[0] = (k < s0 + 3) ? 1'b1 : (((k - s0 - 3) / 4) % 2 == 1);
      e[1] = (((k - s1) / 4) % 2 == 0);
      e[3:2] = 2'b00;
      chk("coin_led", o_led, led_exp(e));
      @(negedge i_clk);
    end
    send_cmd(4'd0, 2'd0, 8'd0, 8'd0, 8'd0);
    send_cmd(4'd1, 2'd0, 8'd0, 8'd0, 8'd0);

    // Reset during an on phase
    send_cmd(4'd2, 2'd2, 8'd4, 8'd4, 8'd0);
    repeat (3) @(negedge i_clk);
    chk("mrst_pre", o_led, led_exp(4'b0100));
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mrst_led", o_led, led_exp(4'b0000));
    chk("mrst_done", o_done, 4'b0000);
    chk("mrst_ready", o_cmd_ready, 1'b0);
    chk("mrst_tick", o_tick, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int r = 0; r < 12; r++) begin
      @(negedge i_clk);
      chk("post_led", o_led, led_exp(4'b0000));
      chk("post_done", o_done, 4'b0000);
    end

    // SOLID once more; polarity follows the build option
    send_cmd(4'd2, 2'd1, 8'd0, 8'd0, 8'd0);
    chk("final_solid", o_led, led_exp(4'b0100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Multi-channel LED pattern sequencer.
- Drives N_LED outputs in one of four modes: off, solid, continuous blink, or counted burst.
- One shared tick prescaler sets the timebase for all channels.
- Loaded through a valid/ready command port; top-level logic uses it to schedule status indications instead of hard-wiring per-LED blink counters.

Parameters:
- N_LED, 4, number of LED channels (1..16).
- TICK_DIV, 25, clock cycles per timebase tick (>=2).
- CNT_W, 8, width of on/off/repeat fields and per-channel counters.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  command accepted when valid&ready.
- i_cmd_led  input  4  target channel index.
- i_cmd_mode  input  2  0=OFF, 1=SOLID, 2=BLINK, 3=BURST.
- i_cmd_on  input  CNT_W  on-phase length in ticks.
- i_cmd_off  input  CNT_W  off-phase length in ticks.
- i_cmd_rep  input  CNT_W  burst pulse count (BURST only).
- o_led  output  N_LED  LED drive, 1=lit.
- o_done  output  N_LED  1-cycle pulse when a channel's burst completes.
- o_tick  output  1  1-cycle timebase pulse.

Behaviour:
- Reset:
  - o_led=0, o_done=0, o_tick=0, o_cmd_ready=0.
  - Prescaler=0; every channel mode=OFF, state=IDLE, counters=0.
- o_cmd_ready is registered. It goes 1 on the first cycle after i_rst deasserts and stays 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - o_tick=1 for the cycle in which count==TICK_DIV-1.
  - First tick is on cycle TICK_DIV after reset release.
  - Free-running; never reset by commands.
- Command acceptance: valid&ready at a rising edge. The target channel's registers update on that edge, and o_led reflects the new mode on the following cycle.
- Zero-length fields: on, off and rep values of 0 are treated as 1.
- Out-of-range i_cmd_led (>=N_LED): accepted and ignored.
- Per-channel states: IDLE, PH_ON, PH_OFF.
  - OFF: state=IDLE, led=0.
  - SOLID: state=IDLE, led=1.
  - BLINK/BURST load: state=PH_ON, cnt=on-1, rep_left=rep, led=1.
  - PH_ON, on tick: if cnt==0, go to PH_OFF with cnt=off-1 and led=0; else cnt-1.
  - PH_OFF, on tick, cnt!=0: cnt-1.
  - PH_OFF, on tick, cnt==0, BLINK: go to PH_ON with cnt=on-1 and led=1.
  - PH_OFF, on tick, cnt==0, BURST with rep_left>1: rep_left-1, go to PH_ON.
  - PH_OFF, on tick, cnt==0, BURST with rep_left<=1: mode=OFF, state=IDLE, led=0, o_done[ch]=1 for one cycle.
- Phase timing: each phase ends on the Nth tick after it starts. The first phase after a load is therefore between N-1 and N ticks long, because the tick is not aligned to the command.
- Simultaneous command and tick on the same channel: the command wins and that tick is ignored for that channel. Other channels still advance.
- A command to a channel mid-BLINK or mid-BURST overrides it immediately; no o_done is emitted.
- Reset asserted mid-operation returns everything to reset values on the next edge; no o_done is emitted.
- Counters never underflow; cnt only decrements when nonzero.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: o_led is the bitwise inverse of the internal lit state, so the reset value is all-ones. o_done and o_tick are unaffected.
- Undefined: o_led = lit state (1=lit), reset value is 0.

Test Plan:
All scenarios use N_LED=4, TICK_DIV=4, CNT_W=8, macro undefined unless noted.
- Reset/timebase: hold i_rst 3 cycles, release -> o_led=0 and ready=0 during reset; ready=1 on the first cycle after release; o_tick high on cycles 4, 8, 12 after release.
- SOLID/OFF: cmd led=2 mode=1 -> o_led=4'b0100 next cycle, stays through 10 ticks; cmd led=2 mode=0 -> o_led=0 next cycle.
- BLINK: cmd led=0 mode=2 on=2 off=3 -> after the first full period, o_led[0] high 8 cycles / low 12 cycles, repeating; o_done stays 0.
- BURST: cmd led=1 mode=3 on=1 off=1 rep=3 -> three o_led[1] pulses (later ones 4 cycles high / 4 low); exactly one o_done[1] pulse, at the end of the third off phase; o_led[1]=0 afterward.
- Override/edge cases:
  - Mid-burst, cmd led=1 mode=1 -> o_led[1]=1 next cycle, no o_done.
  - Cmd with on=0, off=0 -> 1-tick phases.
  - Cmd led=5 -> no o_led change.
  - Command coincident with o_tick -> new mode loads, that tick ignored for the channel.
- Reset mid-BLINK, and LED_ACTIVE_LOW_EN: assert i_rst during PH_ON -> o_led=0, no o_done; rerun SOLID with the macro defined -> o_led=4'b1111 in reset, 4'b1011 after cmd led=2 SOLID.
